data_mem_pipe: RTL and testbench
================================

Name: data_mem_pipe

Overview:
Parametrised, pipelined successor to the CPU's single-cycle data memory.
- Word-organised RAM with byte-lane stores and sign/zero-extended sub-word loads at any naturally aligned byte offset.
- Configurable read latency, valid/ready request and response handshakes with full-pipeline stall, and misalignment/out-of-range error reporting.
- Sits between the MEM stage and the on-chip data RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536.
- READ_LAT, 1, cycles from request accept to response valid; 1..4.
- INIT_FILE, "", hex file loaded via $readmemh at elaboration; empty string means the array is uninitialised.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and reported as an error.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range, or illegal size.
- err_count  out  16  saturating count of errored requests.

Behaviour:
- Reset value of every output register: rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0. All pipeline valid bits are cleared. Memory contents are untouched.
- req_ready = !rst && !stall, where stall = rsp_valid && !rsp_ready.
- Stall behaviour: the whole pipeline holds, and no internal stage may advance or drop data.
- Address decode:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Out of range: any of req_addr[31:log2(DEPTH_WORDS)+2] is nonzero.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- Error requests:
  - No array read or write takes place.
  - The request still produces exactly one response with rsp_err=1 and rsp_rdata=0.
  - err_count increments by 1 on accept and saturates at 16'hFFFF.
- Little-endian lanes:
  - Byte lane = addr[1:0].
  - Half occupies lanes {addr[1],0} and {addr[1],1}.
- Stores:
  - The array is written at the accept edge, and only the selected lanes change.
  - byte: lane addr[1:0] ← wdata[7:0].
  - half: lanes ← wdata[15:0].
  - word: all four lanes ← wdata.
  - One response is returned with rsp_err=0 and rsp_rdata=0 after the same READ_LAT as a load, so ordering is preserved.
- Loads:
  - The array is read at the accept edge. The selected lanes are shifted to bit 0, then extended to 32 bits per req_signed.
  - Word loads ignore req_signed.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+READ_LAT-1, so it is visible in cycle N+READ_LAT, provided there was no stall. Each stall cycle adds one cycle.
- Throughput: one request per cycle; responses are returned in request order.
- Ordering: a load accepted the cycle after a store to the same word returns the newly stored data. Only one request is accepted per cycle, so a same-cycle read/write conflict cannot occur.
- Response stage: the output holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
- Reset mid-operation:
  - All in-flight responses are discarded. rsp_valid=0 on the cycle after the rst edge.
  - Stores already written remain written.
  - A req_valid asserted during rst is not accepted and causes no write.
- req_size=11 is treated as an error regardless of address.

Test Plan:
- Reset, READ_LAT=1: word store 0xDEADBEEF to addr 0x10, then word load from 0x10 the next cycle → rsp_rdata=0xDEADBEEF, rsp_err=0, one cycle after accept.
- Sub-word stores/loads on word 0x8 = 0x11223344:
  - byte store 0xAA at 0x9 → word reads 0x1122AA44.
  - signed byte load at 0x9 → 0xFFFFFFAA; unsigned → 0x000000AA.
  - signed half load at 0xA → 0x00001122.
- Errors:
  - half load at 0x3 → rsp_err=1, rsp_rdata=0.
  - word store at 0x1000 with DEPTH_WORDS=1024 → rsp_err=1, memory unchanged.
  - req_size=11 → rsp_err=1.
  - err_count=3 after these three requests.
- Backpressure, READ_LAT=3: issue 5 back-to-back loads with rsp_ready held low from cycle 2 to cycle 6 → req_ready drops while rsp_valid && !rsp_ready. All 5 responses arrive in order with correct data, with no loss or duplication.
- Reset mid-flight: 3 loads in flight, then rst pulsed for 1 cycle → no responses emitted; err_count=0; data from a store accepted before rst is still readable afterwards.
- Saturation: force 65,537 error requests → err_count holds at 0xFFFF.

Source files
------------

// File: rtl/data_mem_pipe.sv
// Pipelined data RAM: byte-lane stores, sign/zero-extended sub-word loads, error reporting.
// Latency READ_LAT cycles from accept to response; a held response freezes every stage and drops req_ready.
module data_mem_pipe #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    READ_LAT    = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } stage_t;

  logic [31:0]   r_mem [DEPTH_WORDS];
  stage_t        r_stg [READ_LAT];
  logic [15:0]   r_err_cnt;

  logic          w_stall;
  logic          w_accept;
  logic          w_oor;
  logic          w_misal;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_wlanes;
  logic [3:0]    w_be;
  stage_t        w_stg0;

  assign w_stall   = r_stg[READ_LAT-1].vld && !rsp_ready;
  assign req_ready = !rst && !w_stall;
  assign w_accept  = req_valid && req_ready;

  assign w_idx   = req_addr[AW+1:2];
  assign w_oor   = |req_addr[31:AW+2];
  assign w_misal = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err   = w_oor || w_misal || (req_size == 2'b11);

  // Asynchronous read so a load right after a store sees the stored data.
  assign w_rword = r_mem[w_idx];

  always_comb begin
    w_byte = w_rword[7:0];
    case (req_addr[1:0])
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      2'd3:    w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
    w_half = req_addr[1] ? w_rword[31:16] : w_rword[15:0];

    w_load = w_rword;
    case (req_size)
      2'b00:   w_load = {{24{req_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{req_signed & w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // Replicate store data across lanes; the byte enables pick which lanes land.
  always_comb begin
    w_wlanes = req_wdata;
    w_be     = 4'b0000;
    case (req_size)
      2'b00: begin
        w_wlanes = {4{req_wdata[7:0]}};
        w_be     = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wlanes = {2{req_wdata[15:0]}};
        w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_stg0.vld = w_accept;
    w_stg0.err = w_accept && w_err;
    w_stg0.dat = (w_accept && !req_we && !w_err) ? w_load : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  // Bubbles hold along with valid entries so per-request latency grows by exactly one per stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) r_stg[i] <= '0;
      r_err_cnt <= 16'h0;
    end else begin
      if (!w_stall) begin
        r_stg[0] <= w_stg0;
        for (int i = 1; i < READ_LAT; i++) r_stg[i] <= r_stg[i-1];
      end
      if (w_accept && w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign rsp_valid = r_stg[READ_LAT-1].vld;
  assign rsp_err   = r_stg[READ_LAT-1].err;
  assign rsp_rdata = r_stg[READ_LAT-1].dat;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: two instances (READ_LAT 1 and 3) checked against a byte-array reference model.
module tb_data_mem_pipe;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;
  localparam int LAT0   = 1;
  localparam int LAT1   = 3;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [31:0] req_addr [2];
  logic [1:0]  req_size [2];
  logic        req_signed [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];
  logic [15:0] err_count [2];

  always #5 clk = ~clk;

  data_mem_pipe #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
    .req_signed(req_signed[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .err_count(err_count[0]));

  data_mem_pipe #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
    .req_signed(req_signed[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .err_count(err_count[1]));

  logic [7:0]  mem [2][NBYTES];
  exp_t        sb [2][16];
  int          sb_n [2];
  int          mdl_err [2];
  int          rsp_cnt [2];
  logic        prev_stall [2];
  logic        acc_seen [2];
  logic        rnd_rdy [2];
  logic [31:0] last_dat [2];
  logic        last_err [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(int d, string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL dut%0d %s: observed %h expected %h", d, tag, obs, expv);
    end
  endtask

  // Reference: byte-addressed memory, response value computed from the request rules.
  task automatic model_accept(int d);
    logic [31:0] a;
    logic [31:0] v;
    logic        err;
    int          n;
    a   = req_addr[d];
    n   = 1 << req_size[d];
    err = (req_size[d] == 2'd3) || (a >= NBYTES) || ((a % 32'(n)) != 0);
    v   = 32'h0;
    if (err) begin
      if (mdl_err[d] < 65535) mdl_err[d]++;
    end else if (req_we[d]) begin
      for (int k = 0; k < n; k++) mem[d][a + 32'(k)] = req_wdata[d][8*k +: 8];
    end else begin
      for (int k = 0; k < n; k++) v = v | (32'(mem[d][a + 32'(k)]) << (8*k));
      if (req_signed[d] && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    end
    sb[d][sb_n[d]] = '{dat: v, err: err, due: cyc + lat_of(d)};
    sb_n[d]++;
  endtask

  task automatic mon(int d);
    logic stall_now;
    acc_seen[d] = 1'b0;
    chk(d, "err_count", 32'(err_count[d]), 32'(mdl_err[d]));
    chk(d, "req_ready", 32'(req_ready[d]), 32'(!rst && !(rsp_valid[d] && !rsp_ready[d])));
    stall_now = rsp_valid[d] && !rsp_ready[d];
    if (rsp_valid[d]) begin
      if (sb_n[d] == 0) begin
        chk(d, "spurious_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      end else begin
        if (!prev_stall[d]) chk(d, "latency_cycle", 32'(cyc), 32'(sb[d][0].due));
        chk(d, "rsp_rdata", rsp_rdata[d], sb[d][0].dat);
        chk(d, "rsp_err", 32'(rsp_err[d]), 32'(sb[d][0].err));
        if (rsp_ready[d]) begin
          last_dat[d] = rsp_rdata[d];
          last_err[d] = rsp_err[d];
          rsp_cnt[d]++;
          for (int i = 0; i < sb_n[d] - 1; i++) sb[d][i] = sb[d][i+1];
          sb_n[d]--;
        end else begin
          for (int i = 1; i < sb_n[d]; i++) sb[d][i].due++;
        end
      end
    end else if ((sb_n[d] > 0) && (cyc >= sb[d][0].due)) begin
      chk(d, "rsp_missing", 32'(rsp_valid[d]), 32'd1);
    end
    prev_stall[d] = stall_now;
    if (rst) begin
      sb_n[d]       = 0;
      mdl_err[d]    = 0;
      prev_stall[d] = 1'b0;
    end else if (req_valid[d] && req_ready[d]) begin
      model_accept(d);
      acc_seen[d] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    mon(0);
    mon(1);
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) if (rnd_rdy[d]) rsp_ready[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(int d, logic we, logic [31:0] addr, logic [1:0] sz, logic sgn, logic [31:0] wd);
    int n;
    n = 0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_size[d] = sz; req_signed[d] = sgn; req_wdata[d] = wd;
    do begin
      cycle();
      n++;
    end while (!acc_seen[d] && (n < 200));
    if (!acc_seen[d]) chk(d, "accept_timeout", 32'(acc_seen[d]), 32'd1);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while ((sb_n[d] > 0) && (n < 200)) begin
      cycle();
      n++;
    end
    chk(d, "drain_pending", 32'(sb_n[d]), 32'd0);
  endtask

  task automatic ld_chk(int d, logic [31:0] addr, logic [1:0] sz, logic sgn, logic [31:0] expv, string tag);
    send(d, 1'b0, addr, sz, sgn, 32'h0);
    drain(d);
    chk(d, tag, last_dat[d], expv);
  endtask

  initial begin
    int          idx;
    int          cnt_before;
    int          d;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] w84;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'h0; req_size[i] = 2'b00;
      req_signed[i] = 1'b0; req_wdata[i] = 32'h0; rsp_ready[i] = 1'b1; rnd_rdy[i] = 1'b0;
      sb_n[i] = 0; mdl_err[i] = 0; rsp_cnt[i] = 0; prev_stall[i] = 1'b0; acc_seen[i] = 1'b0;
      last_dat[i] = 32'h0; last_err[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      chk(i, "reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk(i, "reset_rsp_rdata", rsp_rdata[i], 32'd0);
      chk(i, "reset_rsp_err", 32'(rsp_err[i]), 32'd0);
      chk(i, "reset_err_count", 32'(err_count[i]), 32'd0);
    end
    rst = 1'b0;

    // Give the first 256 bytes defined contents so every later load has a known answer.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) send(i, 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom());
      drain(i);
    end

    send(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF);
    send(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0);
    drain(0);
    chk(0, "store_then_load_word", last_dat[0], 32'hDEAD_BEEF);
    chk(0, "store_then_load_err", 32'(last_err[0]), 32'd0);

    send(0, 1'b1, 32'h8, 2'b10, 1'b0, 32'h1122_3344);
    send(0, 1'b1, 32'h9, 2'b00, 1'b0, 32'h0000_00AA);
    ld_chk(0, 32'h8, 2'b10, 1'b0, 32'h1122_AA44, "byte_store_word");
    ld_chk(0, 32'h9, 2'b00, 1'b1, 32'hFFFF_FFAA, "lb_signed");
    ld_chk(0, 32'h9, 2'b00, 1'b0, 32'h0000_00AA, "lb_unsigned");
    ld_chk(0, 32'hA, 2'b01, 1'b1, 32'h0000_1122, "lh_signed_upper");
    ld_chk(0, 32'h8, 2'b01, 1'b1, 32'hFFFF_AA44, "lh_signed_lower_neg");

    send(0, 1'b1, 32'h0, 2'b10, 1'b0, 32'h0102_0304);
    ld_chk(0, 32'h3, 2'b01, 1'b0, 32'h0, "misaligned_half_rdata");
    chk(0, "misaligned_half_err", 32'(last_err[0]), 32'd1);
    send(0, 1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFE_F00D);
    drain(0);
    chk(0, "oor_store_err", 32'(last_err[0]), 32'd1);
    ld_chk(0, 32'h0, 2'b10, 1'b0, 32'h0102_0304, "oor_store_no_write");
    send(0, 1'b0, 32'h20, 2'b11, 1'b0, 32'h0);
    drain(0);
    chk(0, "size11_err", 32'(last_err[0]), 32'd1);
    chk(0, "err_count_three", 32'(err_count[0]), 32'd3);

    // Five back-to-back loads into the 3-deep pipe with the consumer stalled mid-stream.
    idx = 0;
    cnt_before = rsp_cnt[1];
    for (int k = 0; (k < 60) && ((idx < 5) || (sb_n[1] > 0)); k++) begin
      rsp_ready[1] = !((k >= 2) && (k <= 6));
      if (idx < 5) begin
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'(32'h40 + 4 * idx);
        req_size[1] = 2'b10; req_signed[1] = 1'b0;
      end else begin
        req_valid[1] = 1'b0;
      end
      cycle();
      if (acc_seen[1]) idx++;
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    chk(1, "bp_requests_accepted", 32'(idx), 32'd5);
    chk(1, "bp_responses", 32'(rsp_cnt[1] - cnt_before), 32'd5);

    rnd_rdy[0] = 1'b1;
    rnd_rdy[1] = 1'b1;
    for (int it = 0; it < 400; it++) begin
      d    = it % 2;
      sz   = 2'($urandom_range(0, 3));
      mask = ~((32'd1 << sz) - 32'd1);
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 | $urandom();
        1:       addr = 32'($urandom_range(0, 255));
        default: addr = 32'($urandom_range(0, 255)) & mask;
      endcase
      send(d, 1'($urandom_range(0, 1)), addr, sz, 1'($urandom_range(0, 1)), $urandom());
    end
    rnd_rdy[0] = 1'b0;
    rnd_rdy[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    drain(0);
    drain(1);

    // Reset with loads in flight; a store attempted during reset must not land.
    send(1, 1'b0, 32'h20, 2'b11, 1'b0, 32'h0);
    send(1, 1'b1, 32'h80, 2'b10, 1'b0, 32'h5A5A_A5A5);
    drain(1);
    rsp_ready[1] = 1'b0;
    send(1, 1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    send(1, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0);
    send(1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0);
    cnt_before = rsp_cnt[1];
    rst = 1'b1;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h84;
    req_size[1] = 2'b10; req_wdata[1] = 32'hFFFF_FFFF;
    cycle();
    rst = 1'b0;
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    repeat (6) cycle();
    chk(1, "rst_no_responses", 32'(rsp_cnt[1] - cnt_before), 32'd0);
    chk(1, "rst_err_count", 32'(err_count[1]), 32'd0);
    ld_chk(1, 32'h80, 2'b10, 1'b0, 32'h5A5A_A5A5, "store_survives_rst");
    w84 = {mem[1][32'h87], mem[1][32'h86], mem[1][32'h85], mem[1][32'h84]};
    ld_chk(1, 32'h84, 2'b10, 1'b0, w84, "no_write_during_rst");

    for (int i = 0; i < 65537; i++) send(0, 1'b0, 32'h30, 2'b11, 1'b0, 32'h0);
    drain(0);
    chk(0, "err_count_saturated", 32'(err_count[0]), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
